// File: rtl/multicycle_core.sv
// Small multicycle accumulator-style core: fetch/exec/mem sequencing over a
// tiny register file, combinational instruction ROM and handshaked data memory.
module multicycle_core #(
    parameter int DW   = 8,
    parameter int IW   = 9,
    parameter int PCW  = 10,
    parameter int NREG = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [PCW-1:0]          StartAddr,
    output logic                    Ack,
    output logic [PCW-1:0]          InstAddr,
    input  logic [IW-1:0]           InstData,
    output logic                    DmReq,
    output logic                    DmWe,
    output logic [DW-1:0]           DmAddr,
    output logic [DW-1:0]           DmWData,
    input  logic [DW-1:0]           DmRData,
    input  logic                    DmReady,
    input  logic [$clog2(NREG)-1:0] DbgSel,
    output logic [DW-1:0]           DbgData,
    output logic [31:0]             InstCount
);

    // state  | meaning
    // IDLE   | waiting for Start; PC/count loaded on acceptance
    // FETCH  | latch InstData into IR
    // EXEC   | ALU/LDI/BRZ retire, LD/ST move to MEM, HALT moves to DONE
    // MEM    | data-memory request held until DmReady
    // DONE   | Ack high until Start drops

    localparam int RW = $clog2(NREG);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;
    localparam logic [2:0] OP_LD  = 3'b101;
    localparam logic [2:0] OP_ST  = 3'b110;
    localparam logic [2:0] OP_BR  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PCW-1:0]  pc, pc_nxt;
    logic [IW-1:0]   ir;
    logic [DW-1:0]   rf [NREG];
    logic [31:0]     inst_count;

    logic [2:0]      op;
    logic [RW-1:0]   ra, rb;
    logic [IW-4:0]   imm;
    logic [DW-1:0]   alu_res, ldi_val;
    logic [PCW-1:0]  br_off;

    logic            ir_load;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            cnt_inc, cnt_clr;

    assign op      = ir[IW-1:IW-3];
    assign ra      = ir[IW-4 -: RW];
    assign rb      = ir[IW-4-RW -: RW];
    assign imm     = ir[IW-4:0];
    assign ldi_val = DW'(imm);
    assign br_off  = PCW'($signed(imm));

    always_comb begin
        alu_res = '0;
        case (op[1:0])
            2'b00:   alu_res = rf[ra] + rf[rb];
            2'b01:   alu_res = rf[ra] - rf[rb];
            2'b10:   alu_res = rf[ra] & rf[rb];
            default: alu_res = rf[ra] ^ rf[rb];
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_load   = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = ra;
        rf_wdata  = alu_res;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    pc_nxt    = StartAddr;
                    cnt_clr   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_load   = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_LD, OP_ST: state_nxt = S_MEM;
                    OP_BR: begin
                        cnt_inc = 1'b1;
                        if (imm == '0) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_FETCH;
                            pc_nxt    = (rf[0] == '0) ? pc + br_off : pc + PCW'(1);
                        end
                    end
                    OP_LDI: begin
                        rf_we     = 1'b1;
                        rf_waddr  = '0;
                        rf_wdata  = ldi_val;
                        pc_nxt    = pc + PCW'(1);
                        cnt_inc   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: begin
                        rf_we     = 1'b1;
                        pc_nxt    = pc + PCW'(1);
                        cnt_inc   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (DmReady) begin
                    rf_we     = (op == OP_LD);
                    rf_wdata  = DmRData;
                    pc_nxt    = pc + PCW'(1);
                    cnt_inc   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                if (!Start) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Reset discards any in-flight write-back, including a pending LD.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc         <= '0;
            ir         <= '0;
            inst_count <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            pc <= pc_nxt;
            if (ir_load) ir <= InstData;
            if (rf_we)   rf[rf_waddr] <= rf_wdata;
            if (cnt_clr)
                inst_count <= '0;
            else if (cnt_inc && inst_count != '1)
                inst_count <= inst_count + 32'd1;
        end
    end

    assign Ack       = (state == S_DONE);
    assign DmReq     = (state == S_MEM);
    assign DmWe      = (state == S_MEM) && (op == OP_ST);
    assign DmAddr    = rf[rb];
    assign DmWData   = rf[ra];
    assign DbgData   = rf[DbgSel];
    assign InstAddr  = pc;
    assign InstCount = inst_count;

endmodule
